// File: rtl/plab4_net_credit_input_queue.sv
// Credit-based receive queue for one ring channel: circular buffer with registered free-slot count.
// Optional same-cycle bypass on an empty queue when PLAB4_NET_CREDIT_QUEUE_BYPASS_EN is defined.
module plab4_net_credit_input_queue #(
    parameter int p_payload_nbits = 8,
    parameter int p_opaque_nbits  = 8,
    parameter int p_srcdest_nbits = 3,
    parameter int p_num_entries   = 2,
    localparam int c_msg_nbits = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits,
    localparam int c_cnt_nbits = $clog2(p_num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [c_msg_nbits-1:0] enq_msg,
    output logic                   deq_val,
    input  logic                   deq_rdy,
    output logic [c_msg_nbits-1:0] deq_msg,
    output logic [c_cnt_nbits-1:0] num_free,
    output logic                   overflow
);

    localparam int c_ptr_nbits = $clog2(p_num_entries);
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);
    localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_num_entries - 1);

    logic [c_msg_nbits-1:0] r_storage [0:p_num_entries-1];
    logic [c_ptr_nbits-1:0] r_enq_ptr;
    logic [c_ptr_nbits-1:0] r_deq_ptr;
    logic [c_cnt_nbits-1:0] r_count;
    logic [c_cnt_nbits-1:0] r_num_free;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_bypass;
    logic                   w_enq;
    logic                   w_deq;
    logic [c_cnt_nbits-1:0] w_count_next;

    assign w_full  = (r_count == c_full);
    assign w_empty = (r_count == '0);

`ifdef PLAB4_NET_CREDIT_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && enq_val && deq_rdy;
    assign deq_val  = !w_empty || w_bypass;
    assign deq_msg  = w_bypass ? enq_msg : r_storage[r_deq_ptr];
`else
    assign w_bypass = 1'b0;
    assign deq_val  = !w_empty;
    assign deq_msg  = r_storage[r_deq_ptr];
`endif

    // Ready depends only on occupancy, so a same-cycle deq never opens a slot for enq.
    assign enq_rdy  = !w_full;
    assign w_enq    = enq_val && enq_rdy && !w_bypass;
    assign w_deq    = !w_empty && deq_rdy;
    assign num_free = r_num_free;
    assign overflow = r_overflow;

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_deq)
            w_count_next = r_count + c_cnt_nbits'(1);
        else if (w_deq && !w_enq)
            w_count_next = r_count - c_cnt_nbits'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enq_ptr  <= '0;
            r_deq_ptr  <= '0;
            r_count    <= '0;
            r_num_free <= c_full;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq)
                r_enq_ptr <= (r_enq_ptr == c_last) ? '0 : r_enq_ptr + c_ptr_nbits'(1);
            if (w_deq)
                r_deq_ptr <= (r_deq_ptr == c_last) ? '0 : r_deq_ptr + c_ptr_nbits'(1);
            r_count    <= w_count_next;
            r_num_free <= c_full - w_count_next;
            // Upstream sending into a full queue means it ignored its credits.
            if (enq_val && w_full)
                r_overflow <= 1'b1;
        end
    end

    // Storage is left uninitialised by reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_enq)
            r_storage[r_enq_ptr] <= enq_msg;
    end

endmodule

// File: tb/tb_plab4_net_credit_input_queue.sv
// Directed self-checking bench for plab4_net_credit_input_queue at default parameters (N=2, 22-bit msg).
// Expectations for the same-cycle bypass follow PLAB4_NET_CREDIT_QUEUE_BYPASS_EN.
module tb_plab4_net_credit_input_queue;

    localparam int c_msg_nbits = 22;

    logic                   clk;
    logic                   reset;
    logic                   enq_val;
    logic                   enq_rdy;
    logic [c_msg_nbits-1:0] enq_msg;
    logic                   deq_val;
    logic                   deq_rdy;
    logic [c_msg_nbits-1:0] deq_msg;
    logic [1:0]             num_free;
    logic                   overflow;

    int assertCount = 0;
    int failCount   = 0;

    plab4_net_credit_input_queue dut (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .enq_msg  (enq_msg),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .deq_msg  (deq_msg),
        .num_free (num_free),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message layout is {dest, src, opaque, payload}.
    function automatic logic [c_msg_nbits-1:0] mkMsg(input logic [2:0] dest, input logic [2:0] src,
                                                     input logic [7:0] opq, input logic [7:0] pay);
        return {dest, src, opq, pay};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic [c_msg_nbits-1:0] m);
        enq_val = v;
        deq_rdy = r;
        enq_msg = m;
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;

        // 1. Reset then idle
        checkOutput("rst_num_free", 32'(num_free), 32'd2);
        checkOutput("rst_enq_rdy",  32'(enq_rdy),  32'd1);
        checkOutput("rst_deq_val",  32'(deq_val),  32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        tick();

        // 2. Single enq, one-cycle latency
        applyStimulus(1'b1, 1'b0, mkMsg(3'd3, 3'd1, 8'h00, 8'hce));
        #1;
        checkOutput("t2_deq_val_same", 32'(deq_val), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t2_deq_val",  32'(deq_val),  32'd1);
        checkOutput("t2_deq_msg",  32'(deq_msg),  32'(mkMsg(3'd3, 3'd1, 8'h00, 8'hce)));
        checkOutput("t2_num_free", 32'(num_free), 32'd1);
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t2_drain_val",  32'(deq_val),  32'd0);
        checkOutput("t2_drain_free", 32'(num_free), 32'd2);

        // 3. Fill to full, then drain in order
        applyStimulus(1'b1, 1'b0, mkMsg(3'd3, 3'd1, 8'h00, 8'hfe));
        tick();
        applyStimulus(1'b1, 1'b0, mkMsg(3'd3, 3'd1, 8'h00, 8'h09));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t3_enq_rdy_full", 32'(enq_rdy),  32'd0);
        checkOutput("t3_num_free_0",   32'(num_free), 32'd0);
        checkOutput("t3_head_fe",      32'(deq_msg),  32'(mkMsg(3'd3, 3'd1, 8'h00, 8'hfe)));
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        checkOutput("t3_head_09",    32'(deq_msg),  32'(mkMsg(3'd3, 3'd1, 8'h00, 8'h09)));
        checkOutput("t3_num_free_1", 32'(num_free), 32'd1);
        checkOutput("t3_enq_rdy",    32'(enq_rdy),  32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t3_empty",      32'(deq_val),  32'd0);
        checkOutput("t3_num_free_2", 32'(num_free), 32'd2);

        // 4. Streaming at one msg/cycle with occupancy 1
        applyStimulus(1'b1, 1'b0, mkMsg(3'd2, 3'd0, 8'h11, 8'h01));
        tick();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b1, mkMsg(3'd2, 3'd0, 8'h11, 8'(k + 1)));
            #1;
            checkOutput($sformatf("t4_head_%0d", k), 32'(deq_msg), 32'(mkMsg(3'd2, 3'd0, 8'h11, 8'(k))));
            checkOutput($sformatf("t4_rdy_%0d", k),  32'(enq_rdy), 32'd1);
            tick();
            checkOutput($sformatf("t4_free_%0d", k), 32'(num_free), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, '0);
        #1;
        checkOutput("t4_head_6", 32'(deq_msg), 32'(mkMsg(3'd2, 3'd0, 8'h11, 8'h06)));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t4_empty", 32'(deq_val), 32'd0);

        // 5. Credit violation sets sticky overflow and drops the message
        applyStimulus(1'b1, 1'b0, mkMsg(3'd1, 3'd2, 8'h22, 8'h10));
        tick();
        applyStimulus(1'b1, 1'b0, mkMsg(3'd1, 3'd2, 8'h22, 8'h11));
        tick();
        applyStimulus(1'b1, 1'b0, mkMsg(3'd1, 3'd2, 8'h22, 8'haa));
        #1;
        checkOutput("t5_rdy_full",    32'(enq_rdy),  32'd0);
        checkOutput("t5_ovf_before",  32'(overflow), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t5_ovf_set",     32'(overflow), 32'd1);
        checkOutput("t5_free_0",      32'(num_free), 32'd0);
        checkOutput("t5_head_10",     32'(deq_msg),  32'(mkMsg(3'd1, 3'd2, 8'h22, 8'h10)));
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        checkOutput("t5_head_11",     32'(deq_msg),  32'(mkMsg(3'd1, 3'd2, 8'h22, 8'h11)));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t5_no_aa",       32'(deq_val),  32'd0);
        checkOutput("t5_ovf_sticky",  32'(overflow), 32'd1);
        checkOutput("t5_free_2",      32'(num_free), 32'd2);

        // 6. Asynchronous reset mid-cycle with one entry in flight
        applyStimulus(1'b1, 1'b0, mkMsg(3'd4, 3'd5, 8'h33, 8'h20));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6_pre_val", 32'(deq_val), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_val",  32'(deq_val),  32'd0);
        checkOutput("t6_rst_free", 32'(num_free), 32'd2);
        checkOutput("t6_rst_ovf",  32'(overflow), 32'd0);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, mkMsg(3'd4, 3'd5, 8'h33, 8'h55));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6_val_55",  32'(deq_val),  32'd1);
        checkOutput("t6_msg_55",  32'(deq_msg),  32'(mkMsg(3'd4, 3'd5, 8'h33, 8'h55)));
        checkOutput("t6_free_1",  32'(num_free), 32'd1);
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6_empty", 32'(deq_val), 32'd0);

        // Enq on empty with deq_rdy high: bypass or ordinary one-cycle latency
        applyStimulus(1'b1, 1'b1, mkMsg(3'd6, 3'd7, 8'h44, 8'h66));
        #1;
`ifdef PLAB4_NET_CREDIT_QUEUE_BYPASS_EN
        checkOutput("byp_val_same", 32'(deq_val), 32'd1);
        checkOutput("byp_msg_same", 32'(deq_msg), 32'(mkMsg(3'd6, 3'd7, 8'h44, 8'h66)));
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("byp_val_next", 32'(deq_val),  32'd0);
        checkOutput("byp_free",     32'(num_free), 32'd2);
`else
        checkOutput("nobyp_val_same", 32'(deq_val), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("nobyp_val_next", 32'(deq_val),  32'd1);
        checkOutput("nobyp_msg_next", 32'(deq_msg),  32'(mkMsg(3'd6, 3'd7, 8'h44, 8'h66)));
        checkOutput("nobyp_free",     32'(num_free), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/plab4_net_credit_input_queue.md
Name: plab4_net_credit_input_queue

Overview:
Receive-side input buffer on one ring channel of a router. It accepts net messages from the upstream router's output port over a val/rdy handshake and stores them in a circular buffer. It presents them to the local router input over val/rdy. It reports its free-entry count upstream, which the upstream router consumes as num_free_prev or num_free_next for credit-based injection and bubble decisions.

Parameters:
p_payload_nbits, 8, payload field width
p_opaque_nbits, 8, opaque field width
p_srcdest_nbits, 3, src and dest field width each
p_num_entries, 2, buffer depth; integer >= 2
Derived: c_msg_nbits = VC_NET_MSG_NBITS(p,o,s); c_cnt_nbits = clog2(p_num_entries+1), which is 2 at default.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset; state clears immediately while low
enq_val  in  1  upstream message valid
enq_rdy  out  1  queue can accept
enq_msg  in  c_msg_nbits  upstream net message
deq_val  out  1  head entry valid
deq_rdy  in  1  router input accepts head
deq_msg  out  c_msg_nbits  head entry, registered storage output
num_free  out  c_cnt_nbits  free entries, to upstream router
overflow  out  1  sticky credit-violation flag

Behaviour:
- Reset (reset low, async):
  - count = 0, enq_ptr = deq_ptr = 0, overflow = 0.
  - Outputs: deq_val = 0, enq_rdy = 1, num_free = p_num_entries.
  - deq_msg is don't-care; storage is not cleared.
- Transfer rules:
  - Enq occurs when enq_val && enq_rdy.
  - Deq occurs when deq_val && deq_rdy.
  - enq_rdy = (count != p_num_entries); it is not dependent on deq_rdy in the same cycle, so there is no combinational rdy path.
  - deq_val = (count != 0).
  - deq_msg = storage[deq_ptr].
- Latency: a message enqueued in cycle t is visible on deq_val/deq_msg in cycle t+1 at earliest (without the optional feature).
- Pointer and count update on each posedge:
  - Each pointer increments on its own transfer.
  - Each pointer wraps from p_num_entries-1 to 0; p_num_entries need not be a power of two.
  - count += enq - deq.
- Simultaneous enq and deq with 0 < count < N: count unchanged, both pointers advance, FIFO order preserved.
- Full (count == N): enq_rdy = 0.
  - A deq in that cycle frees one slot for the next cycle only; it does not allow an enq in the same cycle.
- Empty (count == 0): deq_val = 0; deq_rdy is ignored.
- num_free:
  - Registered, equal to p_num_entries - count at all times after reset.
  - Updates in the cycle after a transfer.
  - Range is 0..p_num_entries; it never goes negative and never exceeds N.
- overflow:
  - Set on the posedge when enq_val == 1 while count == N. This means upstream sent without credit.
  - Stays set until reset.
  - The message offered in that cycle is not stored and the queue state is unchanged.
- Message fields pass through bit-exact; the block does not inspect dest, src, opaque or payload.
- Reset asserted mid-transfer: all in-flight entries are discarded. After reset deasserts, the first enq lands at entry 0.

Optional Feature:
Macro: PLAB4_NET_CREDIT_QUEUE_BYPASS_EN.
- Defined: when count == 0 and enq_val && deq_rdy, the message goes combinationally to deq_msg with deq_val = 1 in the same cycle.
  - It is not written to storage.
  - count, pointers and num_free are unchanged.
  - If deq_rdy == 0, the message is enqueued normally.
- Undefined: there is no combinational path from enq to deq; minimum latency is 1 cycle.

Test Plan:
1. Reset then idle (s=3, N=2) -> num_free=2, enq_rdy=1, deq_val=0, overflow=0.
2. Enq msg {dest=3,src=1,opq=00,pay=ce} in cycle t with deq_rdy=0 -> deq_val=1 at t+1 with identical msg; num_free=1 at t+1.
3. Enq two msgs (pay=fe, then pay=09) with deq_rdy=0 -> enq_rdy=0, num_free=0. Then raise deq_rdy -> msgs dequeue fe then 09 on consecutive cycles; num_free returns 1, then 2.
4. Hold enq_val=1 and deq_rdy=1 continuously for 6 msgs (pay=01..06) after an initial fill of 1 -> steady throughput of one msg/cycle, count stays 1, order 01..06, pointers wrap with no loss.
5. Fill to N=2, then assert enq_val with pay=aa -> overflow=1 next cycle; pay=aa never appears at deq; overflow remains 1 until reset.
6. Pulse reset low asynchronously between edges while count=1 -> deq_val=0 and num_free=2 immediately. Next enq pay=55 appears with no stale data. With the bypass macro defined, an enq on empty with deq_rdy=1 gives deq_val in the same cycle and num_free stays 2.
